// File: rtl/mem_store_buffer.sv
// mem_store_buffer: queues sized stores from the MEM stage and drains one per
// cycle into the data memory write port.
//   st_*      : store request in; st_ready = !full (from registered count)
//   ld_*      : load address conflict check against pending stores
//   dm_*      : data memory write port, driven from the head entry
//   misalign  : one-cycle registered pulse for a rejected illegal store
//   count     : occupied entries; empty = (count == 0)
module mem_store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  input  logic [31:0]              st_pc,
  input  logic                     ld_check,
  input  logic [31:0]              ld_addr,
  output logic                     ld_conflict,
  output logic                     dm_we,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_data,
  output logic [3:0]               dm_be,
  output logic [31:0]              dm_pc,
  output logic                     misalign,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;

  logic             legal;
  logic             enq;
  logic             deq;
  logic             full;
  logic [3:0]       be_new;
  logic [31:0]      data_new;
  logic [PTR_W-1:0] offset;
  logic             ld_hit;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign st_ready = !full;
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign misalign = misalign_q;

  // Lane alignment and legality of the incoming store
  always_comb begin
    legal    = 1'b1;
    be_new   = 4'b0000;
    data_new = 32'h0;
    case (st_size)
      2'b00: begin
        be_new   = 4'b0001 << st_addr[1:0];
        data_new = {4{st_data[7:0]}};
      end
      2'b01: begin
        legal    = !st_addr[0];
        be_new   = st_addr[1] ? 4'b1100 : 4'b0011;
        data_new = {2{st_data[15:0]}};
      end
      2'b10: begin
        legal    = (st_addr[1:0] == 2'b00);
        be_new   = 4'b1111;
        data_new = st_data;
      end
      default: legal = 1'b0;
    endcase
  end

  // Queue control: the memory always accepts, so any valid head drains
  always_comb begin
    enq        = st_valid && st_ready && legal;
    deq        = !empty;
    misalign_d = st_valid && st_ready && !legal;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (deq) head_d = head_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Entry storage needs no reset: validity comes from head/count
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= data_new;
      be_q[tail_q]   <= be_new;
      pc_q[tail_q]   <= st_pc;
    end
  end

  // Head entry drives the memory port; zeros when empty
  always_comb begin
    dm_we   = !empty;
    dm_addr = 32'h0;
    dm_data = 32'h0;
    dm_be   = 4'b0000;
    dm_pc   = 32'h0;
    if (!empty) begin
      dm_addr = {addr_q[head_q][31:2], 2'b00};
      dm_data = data_q[head_q];
      dm_be   = be_q[head_q];
      dm_pc   = pc_q[head_q];
    end
  end

  // An entry is live when its distance from head is below count
  always_comb begin
    ld_hit = 1'b0;
    offset = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      offset = PTR_W'(i) - head_q;
      if ((CNT_W'(offset) < count_q) && (addr_q[i][31:2] == ld_addr[31:2]))
        ld_hit = 1'b1;
    end
    ld_conflict = ld_check && ld_hit;
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer (DEPTH=2): alignment, drain order,
// misalign rejection, load conflict, and reset discarding pending stores.
module tb_mem_store_buffer;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic [31:0] st_pc;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic        misalign;
  logic [1:0]  count;
  logic        empty;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size), .st_pc(st_pc),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_data(dm_data), .dm_be(dm_be),
    .dm_pc(dm_pc), .misalign(misalign), .count(count), .empty(empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic [31:0] pc);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    st_pc    = pc;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    st_size = '0; st_pc = '0; ld_check = 1'b0; ld_addr = '0;
    tick(); tick();
    reset = 1'b0;
    ld_check = 1'b1;
    #1;
    check("rst_count",    32'(count), 32'd0);
    check("rst_empty",    32'(empty), 32'd1);
    check("rst_ready",    32'(st_ready), 32'd1);
    check("rst_we",       32'(dm_we), 32'd0);
    check("rst_be",       32'(dm_be), 32'd0);
    check("rst_addr",     dm_addr, 32'd0);
    check("rst_data",     dm_data, 32'd0);
    check("rst_pc",       dm_pc, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_conflict", 32'(ld_conflict), 32'd0);
    ld_check = 1'b0;

    // Byte store into lane 3
    drive_st(32'h13, 32'hAB, 2'b00, 32'h1000);
    tick();
    st_valid = 1'b0;
    check("b_we",    32'(dm_we), 32'd1);
    check("b_addr",  dm_addr, 32'h10);
    check("b_be",    32'(dm_be), 32'h8);
    check("b_data",  dm_data, 32'hABABABAB);
    check("b_pc",    dm_pc, 32'h1000);
    check("b_count", 32'(count), 32'd1);
    tick();
    check("b_empty", 32'(empty), 32'd1);
    check("b_we0",   32'(dm_we), 32'd0);

    // Half then word, back to back
    drive_st(32'h22, 32'h1234, 2'b01, 32'h2000);
    tick();
    drive_st(32'h24, 32'hDEADBEEF, 2'b10, 32'h2004);
    check("h_be",   32'(dm_be), 32'hC);
    check("h_data", dm_data, 32'h12341234);
    check("h_addr", dm_addr, 32'h20);
    tick();
    st_valid = 1'b0;
    check("w_be",    32'(dm_be), 32'hF);
    check("w_addr",  dm_addr, 32'h24);
    check("w_data",  dm_data, 32'hDEADBEEF);
    check("w_pc",    dm_pc, 32'h2004);
    check("w_count", 32'(count), 32'd1);
    tick();
    check("w_empty", 32'(empty), 32'd1);

    // Five back-to-back stores: each drains the cycle after acceptance
    for (int i = 0; i < 5; i++) begin
      check("f_ready", 32'(st_ready), 32'd1);
      drive_st(32'h200 + 32'(4 * i), 32'h5000 + 32'(i), 2'b10, 32'h3000 + 32'(4 * i));
      tick();
      check("f_count_le", 32'(count <= 2'(DEPTH)), 32'd1);
      check("f_addr", dm_addr, 32'h200 + 32'(4 * i));
      check("f_data", dm_data, 32'h5000 + 32'(i));
      check("f_pc",   dm_pc,   32'h3000 + 32'(4 * i));
    end
    st_valid = 1'b0;
    tick();
    check("f_empty", 32'(empty), 32'd1);

    // Misaligned and illegal stores are rejected
    drive_st(32'h102, 32'h1, 2'b10, 32'h4000);
    tick();
    check("m1_pulse", 32'(misalign), 32'd1);
    check("m1_count", 32'(count), 32'd0);
    check("m1_we",    32'(dm_we), 32'd0);
    drive_st(32'h101, 32'h2, 2'b01, 32'h4004);
    tick();
    check("m2_pulse", 32'(misalign), 32'd1);
    check("m2_count", 32'(count), 32'd0);
    check("m2_we",    32'(dm_we), 32'd0);
    drive_st(32'h100, 32'h3, 2'b11, 32'h4008);
    tick();
    check("m3_pulse", 32'(misalign), 32'd1);
    st_valid = 1'b0;
    tick();
    check("m_clear", 32'(misalign), 32'd0);
    check("m_empty", 32'(empty), 32'd1);

    // Load conflict against pending store to 0x40
    drive_st(32'h40, 32'h77, 2'b10, 32'h5000);
    tick();
    st_valid = 1'b0;
    ld_check = 1'b1; ld_addr = 32'h43; #1;
    check("c_hit", 32'(ld_conflict), 32'd1);
    ld_addr = 32'h44; #1;
    check("c_miss", 32'(ld_conflict), 32'd0);
    ld_check = 1'b0; ld_addr = 32'h43; #1;
    check("c_nochk", 32'(ld_conflict), 32'd0);
    ld_check = 1'b1;
    tick();
    check("c_drained", 32'(ld_conflict), 32'd0);
    ld_check = 1'b0;

    // Reset before the second drain discards pending stores
    drive_st(32'h80, 32'hA, 2'b10, 32'h6000);
    tick();
    drive_st(32'h84, 32'hB, 2'b10, 32'h6004);
    tick();
    check("r_pend_we", 32'(dm_we), 32'd1);
    check("r_pend_addr", dm_addr, 32'h84);
    drive_st(32'h88, 32'hC, 2'b10, 32'h6008);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    st_valid = 1'b0;
    check("r_we",    32'(dm_we), 32'd0);
    check("r_count", 32'(count), 32'd0);
    check("r_ready", 32'(st_ready), 32'd1);
    tick();
    check("r_we2",   32'(dm_we), 32'd0);
    check("r_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
